// File: rtl/column_sweep_scheduler.sv
// Frame sequencer for the per-column slice-height calculator: snapshots the view,
// walks every column, clamps each height and hands it to the slice drawer.
module column_sweep_scheduler #(
    parameter int NUM_COLUMNS    = 160,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int MAX_HEIGHT     = 120
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start_frame,
    input  logic               abort,
    input  logic signed [12:0] playerX,
    input  logic signed [12:0] playerY,
    input  logic signed [9:0]  angle_X,
    input  logic signed [9:0]  angle_Y,
    output logic signed [12:0] calc_playerX,
    output logic signed [12:0] calc_playerY,
    output logic signed [9:0]  calc_angle_X,
    output logic signed [9:0]  calc_angle_Y,
    output logic [7:0]         column_count,
    output logic               begin_calc,
    input  logic               end_calc,
    input  logic [6:0]         slice_size,
    output logic               slice_valid,
    input  logic               slice_ready,
    output logic [7:0]         slice_column,
    output logic [6:0]         slice_height,
    output logic               busy,
    output logic               frame_done,
    output logic               timeout_flag,
    output logic [2:0]         state_dbg
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         LAST_COL   = 8'(NUM_COLUMNS - 1);
    localparam logic [6:0]         HEIGHT_CAP = 7'(MAX_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [7:0]           col_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [6:0]           height_q;
    logic                 timeout_q;
    logic signed [12:0]   snap_px_q;
    logic signed [12:0]   snap_py_q;
    logic signed [9:0]    snap_ax_q;
    logic signed [9:0]    snap_ay_q;

    logic                 load_snap;
    logic                 col_inc;
    logic                 timer_clear;
    logic                 timer_inc;
    logic                 capture_result;
    logic                 capture_timeout;
    logic [6:0]           clamped_size;

    assign clamped_size = (slice_size > HEIGHT_CAP) ? HEIGHT_CAP : slice_size;

    // Drawer handshake: slice_valid is high for the whole of S_PRESENT with the
    // payload frozen; a transfer happens on any edge where valid and ready are both high.
    always_comb begin
        state_d         = state_q;
        load_snap       = 1'b0;
        col_inc         = 1'b0;
        timer_clear     = 1'b0;
        timer_inc       = 1'b0;
        capture_result  = 1'b0;
        capture_timeout = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_frame) begin
                        load_snap = 1'b1;
                        state_d   = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_clear = 1'b1;
                    state_d     = S_WAIT;
                end
                S_WAIT: begin
                    timer_inc = 1'b1;
                    // A reply landing on the final timer cycle still counts as a reply.
                    if (end_calc) begin
                        capture_result = 1'b1;
                        state_d        = S_PRESENT;
                    end else if (timer_q == TIMER_LAST) begin
                        capture_timeout = 1'b1;
                        state_d         = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (slice_ready) begin
                        if (col_q == LAST_COL) begin
                            state_d = S_DONE;
                        end else begin
                            col_inc = 1'b1;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            snap_px_q <= '0;
            snap_py_q <= '0;
            snap_ax_q <= '0;
            snap_ay_q <= '0;
        end else if (load_snap) begin
            snap_px_q <= playerX;
            snap_py_q <= playerY;
            snap_ax_q <= angle_X;
            snap_ay_q <= angle_Y;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_q <= 8'd0;
        end else if (load_snap) begin
            col_q <= 8'd0;
        end else if (col_inc) begin
            col_q <= col_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else if (timer_clear) begin
            timer_q <= '0;
        end else if (timer_inc) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            height_q <= 7'd0;
        end else if (capture_result) begin
            height_q <= clamped_size;
        end else if (capture_timeout) begin
            height_q <= 7'd0;
        end
    end

    // Sticky for the frame; only a new accepted start clears it, an abort does not.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timeout_q <= 1'b0;
        end else if (load_snap) begin
            timeout_q <= 1'b0;
        end else if (capture_timeout) begin
            timeout_q <= 1'b1;
        end
    end

    assign calc_playerX = snap_px_q;
    assign calc_playerY = snap_py_q;
    assign calc_angle_X = snap_ax_q;
    assign calc_angle_Y = snap_ay_q;
    assign column_count = col_q;
    assign slice_column = col_q;
    assign slice_height = height_q;
    assign timeout_flag = timeout_q;
    assign begin_calc   = (state_q == S_ISSUE);
    assign slice_valid  = (state_q == S_PRESENT);
    assign frame_done   = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_column_sweep_scheduler.sv
// Directed bench for column_sweep_scheduler: normal frame, backpressure, timeout,
// coincident reply, snapshot stability, abort and asynchronous reset.
module tb_column_sweep_scheduler;

    localparam int NC = 4;
    localparam int TO = 8;
    localparam int MH = 120;

    logic               clock = 1'b0;
    logic               resetn;
    logic               start_frame;
    logic               abort;
    logic signed [12:0] playerX;
    logic signed [12:0] playerY;
    logic signed [9:0]  angle_X;
    logic signed [9:0]  angle_Y;
    logic signed [12:0] calc_playerX;
    logic signed [12:0] calc_playerY;
    logic signed [9:0]  calc_angle_X;
    logic signed [9:0]  calc_angle_Y;
    logic [7:0]         column_count;
    logic               begin_calc;
    logic               end_calc;
    logic [6:0]         slice_size;
    logic               slice_valid;
    logic               slice_ready;
    logic [7:0]         slice_column;
    logic [6:0]         slice_height;
    logic               busy;
    logic               frame_done;
    logic               timeout_flag;
    logic [2:0]         state_dbg;

    int total  = 0;
    int passed = 0;
    int done_seen = 0;
    int d0;

    logic [6:0] f1_size [4];
    logic [6:0] f1_exp  [4];

    column_sweep_scheduler #(
        .NUM_COLUMNS   (NC),
        .TIMEOUT_CYCLES(TO),
        .MAX_HEIGHT    (MH)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start_frame  (start_frame),
        .abort        (abort),
        .playerX      (playerX),
        .playerY      (playerY),
        .angle_X      (angle_X),
        .angle_Y      (angle_Y),
        .calc_playerX (calc_playerX),
        .calc_playerY (calc_playerY),
        .calc_angle_X (calc_angle_X),
        .calc_angle_Y (calc_angle_Y),
        .column_count (column_count),
        .begin_calc   (begin_calc),
        .end_calc     (end_calc),
        .slice_size   (slice_size),
        .slice_valid  (slice_valid),
        .slice_ready  (slice_ready),
        .slice_column (slice_column),
        .slice_height (slice_height),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_flag (timeout_flag),
        .state_dbg    (state_dbg)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_done === 1'b1) done_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench in cycle 1 of the frame (S_ISSUE, column 0).
    task automatic start_pulse();
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
    endtask

    // From S_ISSUE: check the pulse, reply one cycle later, end up in S_PRESENT.
    task automatic reply(input int col, input logic [6:0] size);
        chk($sformatf("begin_calc_c%0d", col), begin_calc, 1);
        chk($sformatf("column_count_c%0d", col), column_count, col);
        tick();
        chk($sformatf("wait_no_valid_c%0d", col), slice_valid, 0);
        end_calc   = 1'b1;
        slice_size = size;
        tick();
        end_calc   = 1'b0;
    endtask

    task automatic present(input string tag, input int col, input int h);
        chk({tag, "_valid"}, slice_valid, 1);
        chk({tag, "_column"}, slice_column, col);
        chk({tag, "_height"}, slice_height, h);
    endtask

    initial begin
        resetn      = 1'b0;
        start_frame = 1'b0;
        abort       = 1'b0;
        playerX     = '0;
        playerY     = '0;
        angle_X     = '0;
        angle_Y     = '0;
        end_calc    = 1'b0;
        slice_size  = '0;
        slice_ready = 1'b1;
        f1_size = '{7'd50, 7'd127, 7'd0, 7'd119};
        f1_exp  = '{7'd50, 7'd120, 7'd0, 7'd119};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_begin_calc", begin_calc, 0);
        chk("rst_slice_valid", slice_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_timeout_flag", timeout_flag, 0);
        chk("rst_column_count", column_count, 0);
        chk("rst_slice_height", slice_height, 0);
        chk("rst_calc_playerX", calc_playerX, 0);
        chk("rst_state", state_dbg, 0);
        resetn = 1'b1;
        tick();

        // Frame 1: immediate replies, ready held high, clamp at 120.
        playerX = 13'sd100;
        playerY = 13'sd200;
        angle_X = 10'sd3;
        angle_Y = 10'sd17;
        start_pulse();
        for (int k = 0; k < NC; k++) begin
            reply(k, f1_size[k]);
            present($sformatf("f1_c%0d", k), k, f1_exp[k]);
            tick();
        end
        chk("f1_frame_done_cycle13", frame_done, 1);
        chk("f1_busy_in_done", busy, 1);
        chk("f1_timeout_flag", timeout_flag, 0);
        chk("f1_snap_playerY", calc_playerY, 200);
        chk("f1_snap_angle_Y", calc_angle_Y, 17);
        tick();
        chk("f1_done_one_cycle", frame_done, 0);
        chk("f1_idle_busy", busy, 0);

        // Frame 2: backpressure on column 1, timeout on column 2.
        start_pulse();
        reply(0, 7'd10);
        present("f2_c0", 0, 10);
        tick();
        slice_ready = 1'b0;
        reply(1, 7'd20);
        for (int i = 0; i < 5; i++) begin
            present($sformatf("f2_bp%0d", i), 1, 20);
            chk($sformatf("f2_bp%0d_no_issue", i), begin_calc, 0);
            tick();
        end
        present("f2_bp_last", 1, 20);
        slice_ready = 1'b1;
        tick();
        chk("f2_c2_begin_calc", begin_calc, 1);
        chk("f2_c2_column", column_count, 2);
        for (int i = 1; i <= TO; i++) begin
            tick();
            chk($sformatf("f2_to_wait%0d", i), slice_valid, 0);
        end
        tick();
        present("f2_c2_timeout", 2, 0);
        chk("f2_timeout_flag_set", timeout_flag, 1);
        tick();
        reply(3, 7'd127);
        present("f2_c3", 3, 120);
        chk("f2_timeout_flag_sticky", timeout_flag, 1);
        tick();
        chk("f2_frame_done", frame_done, 1);
        chk("f2_timeout_flag_at_done", timeout_flag, 1);
        tick();
        chk("f2_idle_timeout_flag", timeout_flag, 1);

        // Frame 3: reply coincides with the last timer cycle; live inputs move mid-frame.
        playerX = 13'sd100;
        start_pulse();
        chk("f3_timeout_flag_cleared", timeout_flag, 0);
        chk("f3_c0_begin_calc", begin_calc, 1);
        playerX     = 13'sd900;
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        repeat (TO - 1) tick();
        chk("f3_no_early_valid", slice_valid, 0);
        end_calc   = 1'b1;
        slice_size = 7'd33;
        tick();
        end_calc   = 1'b0;
        present("f3_c0_coincident", 0, 33);
        chk("f3_timeout_flag_unchanged", timeout_flag, 0);
        chk("f3_snap_hold", calc_playerX, 100);
        tick();
        reply(1, 7'd1);
        present("f3_c1", 1, 1);
        tick();
        reply(2, 7'd2);
        present("f3_c2", 2, 2);
        tick();
        reply(3, 7'd120);
        present("f3_c3", 3, 120);
        chk("f3_snap_hold_end", calc_playerX, 100);
        d0 = done_seen;
        tick();
        chk("f3_frame_done", frame_done, 1);
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        chk("f3_start_in_done_ignored", busy, 0);
        tick();
        chk("f3_start_not_queued", busy, 0);
        chk("f3_single_frame_done", done_seen - d0, 1);

        // Frame 4: abort while waiting on column 1.
        start_pulse();
        chk("f4_snap_new", calc_playerX, 900);
        reply(0, 7'd40);
        present("f4_c0", 0, 40);
        tick();
        chk("f4_c1_begin_calc", begin_calc, 1);
        tick();
        abort = 1'b1;
        d0 = done_seen;
        tick();
        abort = 1'b0;
        chk("f4_abort_idle", busy, 0);
        chk("f4_abort_no_valid", slice_valid, 0);
        chk("f4_abort_no_begin", begin_calc, 0);
        chk("f4_abort_snap_kept", calc_playerX, 900);
        repeat (3) tick();
        chk("f4_abort_no_frame_done", done_seen - d0, 0);
        chk("f4_stays_idle", busy, 0);

        // Frame 5: asynchronous reset while a result is held.
        start_pulse();
        slice_ready = 1'b0;
        reply(0, 7'd60);
        present("f5_c0", 0, 60);
        #2 resetn = 1'b0;
        #1;
        chk("f5_rst_valid", slice_valid, 0);
        chk("f5_rst_busy", busy, 0);
        chk("f5_rst_begin_calc", begin_calc, 0);
        chk("f5_rst_snap", calc_playerX, 0);
        chk("f5_rst_height", slice_height, 0);
        chk("f5_rst_column", column_count, 0);
        chk("f5_rst_frame_done", frame_done, 0);
        tick();
        resetn      = 1'b1;
        slice_ready = 1'b1;
        tick();
        chk("f5_after_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/column_sweep_scheduler.md
# column_sweep_scheduler

Frame-level sequencer for the per-column slice-height calculator (`find_slice_height`). On each `start_frame` it snapshots player position and view angle, then walks `column_count` from 0 to NUM_COLUMNS-1. For each column it pulses `begin_calc`, waits for `end_calc` and clamps the returned `slice_size`. It hands each result to the slice drawer over a valid/ready handshake and signals frame completion. A watchdog substitutes height 0 for any column whose calculation never finishes.

## Interface
- NUM_COLUMNS, 160, columns per frame (1..256)
- TIMEOUT_CYCLES, 1023, max cycles to wait for `end_calc` after `begin_calc` (≥2)
- MAX_HEIGHT, 120, clamp for delivered slice height (≤127)

- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start_frame  in  1  request a new sweep; sampled only in S_IDLE
- abort  in  1  synchronous; cancel sweep in progress
- playerX, playerY  in  13 signed  live player position
- angle_X, angle_Y  in  10 signed  live view angle (integer / fraction parts)
- calc_playerX, calc_playerY  out  13 signed  frame snapshot driven to calculator
- calc_angle_X, calc_angle_Y  out  10 signed  frame snapshot driven to calculator
- column_count  out  8  current column index
- begin_calc  out  1  one-cycle start pulse to calculator
- end_calc  in  1  calculator finished; `slice_size` valid this cycle
- slice_size  in  7  calculator height result
- slice_valid  out  1  result available to drawer
- slice_ready  in  1  drawer accepts result
- slice_column  out  8  column of presented result (equals `column_count`)
- slice_height  out  7  clamped height of presented result
- busy  out  1  high in any state except S_IDLE
- frame_done  out  1  one-cycle pulse after last column accepted
- timeout_flag  out  1  sticky; at least one column timed out this frame

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_PRESENT, S_DONE. All outputs are decoded from registered state and registered data. There is no combinational path from any input to any output.
- S_IDLE: when `start_frame`=1, register the snapshot (player and angle values), set column to 0, clear `timeout_flag`, then go to S_ISSUE.
- S_ISSUE: `begin_calc`=1. Clear the timer. Go to S_WAIT.
- S_WAIT: the timer increments every cycle.
  - If `end_calc`=1: `slice_height` ← min(`slice_size`, MAX_HEIGHT). Go to S_PRESENT.
  - Otherwise, if timer = TIMEOUT_CYCLES-1: `slice_height` ← 0, set `timeout_flag`. Go to S_PRESENT.
  - `end_calc` wins if it coincides with the timeout.
- S_PRESENT: `slice_valid`=1, with `slice_height` and `slice_column` held stable. When `slice_ready`=1:
  - If column = NUM_COLUMNS-1, go to S_DONE.
  - Otherwise, increment column and go to S_ISSUE.
- S_DONE: `frame_done`=1 for one cycle, then go to S_IDLE.
- `abort`=1 in any non-idle state moves to S_IDLE on the next edge. No `frame_done` pulse. `slice_valid` drops. The snapshot and `timeout_flag` keep their values.
- `start_frame` outside S_IDLE is ignored and not queued.
- `end_calc` outside S_WAIT is ignored.
- Snapshot registers change only on `start_frame` acceptance. Live input changes mid-frame have no effect.
- The timer width is ceil(log2(TIMEOUT_CYCLES+1)). The column counter never exceeds NUM_COLUMNS-1 and has no wrap past it.

## Timing
- Reset (async assert): state S_IDLE. Column 0. All outputs 0, including snapshot, `slice_height` and `timeout_flag`.
- Deassertion takes effect on the next rising edge.
- `start_frame` sampled at edge 0 → `begin_calc` high in cycle 1 for `column_count`=0.
- `end_calc` is recognised no earlier than the cycle after `begin_calc`.
- Minimum per column, with immediate `end_calc` and `slice_ready` held high: 3 cycles (ISSUE, WAIT, PRESENT).
- Minimum frame: `frame_done` at cycle 3·NUM_COLUMNS+1 after the `start_frame` edge.
- Timeout column: `slice_valid` rises TIMEOUT_CYCLES+1 cycles after `begin_calc`.
- `slice_valid` stays high until accepted. The payload does not change while valid and not ready.
- Reset mid-frame: immediate return to S_IDLE. Any held `slice_valid` and `begin_calc` drop asynchronously.

## Test plan
- NUM_COLUMNS=4, ready held high, calculator replies 1 cycle after each `begin_calc` with 50, 127, 0, 119 → delivered heights 50, 120, 0, 119 on columns 0..3. `frame_done` at cycle 13. `timeout_flag`=0.
- Drawer backpressure: `slice_ready` low for 5 cycles on column 1 → `slice_valid`, column 1 and its height stable for all 5 cycles. No second `begin_calc` until accept.
- TIMEOUT_CYCLES=8, `end_calc` never arrives for column 2 → height 0 delivered 9 cycles after `begin_calc`. `timeout_flag`=1 through frame end. Cleared on next `start_frame`.
- `end_calc` coincident with timeout cycle, `slice_size`=33 → height 33 delivered. `timeout_flag` unchanged.
- Change playerX from 100 to 900 mid-frame, and pulse `start_frame` while busy → `calc_playerX` stays 100. No restart. Single `frame_done`.
- `abort` in S_WAIT of column 1, then `resetn` low in S_PRESENT of a new frame → S_IDLE next edge, no `frame_done`. On reset, all outputs 0 immediately.
